// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   uart_rx_state_e : receive FSM state encoding
//   UART_DATA_BITS  : data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync.sv
// N-flop metastability synchroniser. All flops reset to 1 so an idle-high
// line never looks like a falling edge coming out of reset.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output (STAGES cycles of latency)
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 1 start, 8 data (LSB first), optional parity, 1 stop.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_rx                : asynchronous serial line, idle high
//   i_baud_strb         : mid-bit sample strobe from the baud generator
//   o_baud_strb_en      : holds the baud RX counter at 0 while idle
//   i_parity_en/odd     : parity enable / type (1 = odd), sampled per frame
//   o_data, o_valid     : received byte, valid/ready handshake with i_ready
//   o_frame_err         : stop bit sampled low (qualified by o_valid)
//   o_parity_err        : parity mismatch (qualified by o_valid)
//   o_overrun           : one-cycle pulse when a completed byte is dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_baud_strb,
  output logic       o_baud_strb_en,
  input  logic       i_parity_en,
  input  logic       i_parity_odd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e            state, state_nx;
  logic                      rx_s, rx_q;
  logic                      start_edge;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      par_en_q, par_odd_q, par_err_q;
  logic                      deliver;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  // rx_q resets high too, so a line that stays low after a bad stop bit
  // never re-triggers: a fresh high-to-low transition is required.
  always_ff @(posedge clk) begin
    if (!rst_n) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

  assign start_edge = rx_q & ~rx_s;
  assign deliver    = (state == RX_STOP) && i_baud_strb;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:   if (start_edge)  state_nx = RX_START;
      RX_START:  if (i_baud_strb) state_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (i_baud_strb && bit_cnt == LAST_BIT)
                   state_nx = par_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (i_baud_strb) state_nx = RX_STOP;
      RX_STOP:   if (i_baud_strb) state_nx = RX_IDLE;
      default:   state_nx = RX_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_baud_strb_en = (state == RX_IDLE);
  end

  // Frame datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: if (start_edge) begin
          par_en_q  <= i_parity_en;
          par_odd_q <= i_parity_odd;
          par_err_q <= 1'b0;
        end
        RX_START: if (i_baud_strb && !rx_s) bit_cnt <= '0;
        RX_DATA: if (i_baud_strb) begin
          shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 3'd1;
        end
        RX_PARITY: if (i_baud_strb) par_err_q <= rx_s ^ (^shreg) ^ par_odd_q;
        default: ;
      endcase
    end
  end

  // Output holding register; a load in the same cycle as an accept wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (deliver) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_frame_err  <= ~rx_s;
          o_parity_err <= par_err_q & par_en_q;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a small bench-side baud strobe
// generator (16 cycles per bit) and a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned TARGET = 15;
  localparam int unsigned BIT    = TARGET + 1;
  localparam logic [4:0]  HALF   = 5'(TARGET / 2);
  // Edge index of the first strobe measured from the cycle the line falls.
  localparam int unsigned OFS    = SYNC + 2 + TARGET / 2;

  logic       clk, rst_n;
  logic       i_rx, i_baud_strb, o_baud_strb_en;
  logic       i_parity_en, i_parity_odd;
  logic [7:0] o_data;
  logic       o_valid, i_ready, o_frame_err, o_parity_err, o_overrun;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx           (i_rx),
    .i_baud_strb    (i_baud_strb),
    .o_baud_strb_en (o_baud_strb_en),
    .i_parity_en    (i_parity_en),
    .i_parity_odd   (i_parity_odd),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_frame_err    (o_frame_err),
    .o_parity_err   (o_parity_err),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud generator stand-in: counter held at 0 while enabled.
  logic [4:0] bcnt = '0;
  always @(posedge clk) begin
    if (!rst_n || o_baud_strb_en) bcnt <= '0;
    else if (bcnt == 5'(TARGET))  bcnt <= '0;
    else                          bcnt <= bcnt + 5'd1;
  end
  assign i_baud_strb = !o_baud_strb_en && (bcnt == HALF);

  int unsigned cyc = 0;
  int unsigned nowc;
  always @(posedge clk) cyc <= cyc + 1;
  assign nowc = cyc + 1;

  int nchk = 0, nfail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame announcements from the driver to the model.
  int unsigned ann_seq = 0, ann_blo = 0, ann_bhi = 0, ann_dc = 0;
  bit          ann_has = 0;
  logic [9:0]  ann_rec = '0;

  // Reference model: output register behaviour derived from frame contents.
  int unsigned seen_seq = 0, p_blo = 0, p_bhi = 0, p_dc = 0;
  bit          p_has = 0;
  logic [9:0]  p_rec = '0, m_rec = '0;
  logic        mvalid = 0, mov = 0, exp_en = 1;

  always @(posedge clk) begin
    if (ann_seq != seen_seq) begin
      seen_seq <= ann_seq;
      p_blo <= ann_blo; p_bhi <= ann_bhi; p_dc <= ann_dc;
      p_has <= ann_has; p_rec <= ann_rec;
    end
    if (!rst_n) begin
      mvalid <= 0; mov <= 0; exp_en <= 1; m_rec <= '0;
      p_has <= 0; p_bhi <= 0;
    end else begin
      exp_en <= !(nowc >= p_blo && nowc < p_bhi);
      mov <= 0;
      if (p_has && nowc == p_dc) begin
        if (!mvalid || i_ready) begin
          mvalid <= 1; m_rec <= p_rec;
        end else mov <= 1;
      end else if (mvalid && i_ready) mvalid <= 0;
    end
  end

  // Per-cycle comparison and handshake logging.
  bit         chk_on = 0;
  logic [9:0] got_q[$];
  int         ov_cnt = 0, vcnt = 0;
  always begin
    @(negedge clk); #1;
    if (chk_on) begin
      chk("valid",   32'(o_valid),        32'(mvalid));
      chk("overrun", 32'(o_overrun),      32'(mov));
      chk("strb_en", 32'(o_baud_strb_en), 32'(exp_en));
      if (mvalid) begin
        chk("data",     32'(o_data),       32'(m_rec[9:2]));
        chk("frame_er", 32'(o_frame_err),  32'(m_rec[1]));
        chk("par_err",  32'(o_parity_err), 32'(m_rec[0]));
      end
      if (o_valid && i_ready) got_q.push_back({o_data, o_frame_err, o_parity_err});
      if (o_overrun) ov_cnt++;
      if (o_valid)   vcnt++;
    end
  end

  bit rnd_rdy = 0;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (rnd_rdy && $urandom_range(0, 31) == 0) i_ready = ~i_ready;
    end
  endtask

  task automatic announce(input int unsigned blo, bhi, dc, input bit has, input logic [9:0] rec);
    ann_blo = blo; ann_bhi = bhi; ann_dc = dc; ann_has = has; ann_rec = rec;
    ann_seq++;
  endtask

  // Drive one frame starting at the current negedge. The line is left at the
  // stop value afterwards.
  task automatic send(input logic [7:0] d, input bit pen, podd, bad, stop_v);
    int unsigned k, nb, dc;
    k  = cyc;
    nb = pen ? 10 : 9;
    dc = k + OFS + BIT * nb;
    announce(k + 3, dc, dc, 1, {d, ~stop_v, pen & bad});
    i_parity_en = pen; i_parity_odd = podd;
    i_rx = 1'b0;
    tick(BIT);
    // Frame settings were latched at the edge; perturb them mid-frame.
    i_parity_en = 1'($urandom); i_parity_odd = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      tick(BIT);
    end
    if (pen) begin
      i_rx = (^d) ^ podd ^ bad;
      tick(BIT);
    end
    i_rx = stop_v;
    tick(BIT);
  endtask

  int ov0, g0, v0;
  int unsigned k0;

  initial begin
    rst_n = 0; i_rx = 1; i_ready = 0; i_parity_en = 0; i_parity_odd = 0;
    tick(3);
    chk("rst_valid",  32'(o_valid),        0);
    chk("rst_data",   32'(o_data),         0);
    chk("rst_ferr",   32'(o_frame_err),    0);
    chk("rst_perr",   32'(o_parity_err),   0);
    chk("rst_ovr",    32'(o_overrun),      0);
    chk("rst_strben", 32'(o_baud_strb_en), 1);
    chk_on = 1;
    rst_n = 1;
    tick(5);

    // Clean 8N1 byte
    i_ready = 1; v0 = vcnt;
    send(8'h55, 0, 0, 0, 1); tick(4);
    chk("t1_byte",  32'(got_q[$]), 32'({8'h55, 2'b00}));
    chk("t1_vcnt",  32'(vcnt - v0), 1);

    // Even parity: 0xA3 has four ones, so the correct bit is 0
    send(8'hA3, 1, 0, 0, 1); tick(4);
    chk("t2_ok",    32'(got_q[$]), 32'({8'hA3, 2'b00}));
    send(8'hA3, 1, 0, 1, 1); tick(4);
    chk("t2_bad",   32'(got_q[$]), 32'({8'hA3, 2'b01}));
    // Odd parity sanity
    send(8'h07, 1, 1, 0, 1); tick(4);
    chk("t2_odd",   32'(got_q[$]), 32'({8'h07, 2'b00}));

    // Framing error with the line stuck low afterwards
    g0 = got_q.size();
    send(8'h0F, 0, 0, 0, 0);
    tick(3 * BIT);
    i_rx = 1; tick(2 * BIT);
    chk("t3_ferr",  32'(got_q[$]), 32'({8'h0F, 2'b10}));
    chk("t3_once",  32'(got_q.size() - g0), 1);
    send(8'h21, 0, 0, 0, 1); tick(4);
    chk("t3_next",  32'(got_q[$]), 32'({8'h21, 2'b00}));

    // Start glitch: low for a few cycles, high again before the first strobe
    g0 = got_q.size(); k0 = cyc;
    announce(k0 + 3, k0 + OFS, 0, 0, '0);
    i_rx = 0; tick(4); i_rx = 1; tick(2 * BIT);
    chk("t4_novld", 32'(got_q.size() - g0), 0);
    chk("t4_en",    32'(o_baud_strb_en), 1);

    // Overrun
    i_ready = 0; ov0 = ov_cnt;
    send(8'h11, 0, 0, 0, 1);
    send(8'h22, 0, 0, 0, 1); tick(2);
    chk("t5_hold",  32'(o_data), 32'h11);
    chk("t5_vld",   32'(o_valid), 1);
    chk("t5_ovcnt", 32'(ov_cnt - ov0), 1);
    i_ready = 1; tick(1);
    chk("t5_drop",  32'(o_valid), 0);
    chk("t5_acc",   32'(got_q[$]), 32'({8'h11, 2'b00}));

    // Reset mid-frame with a byte held; data 0xF0 keeps the line high after bit 3
    i_ready = 0;
    send(8'h77, 0, 0, 0, 1); tick(4);
    k0 = cyc;
    announce(k0 + 3, 32'hFFFF_FFFF, 0, 0, '0);
    i_rx = 0; tick(BIT);
    for (int i = 0; i < 4; i++) tick(BIT);
    i_rx = 1; tick(2);
    rst_n = 0; tick(2); rst_n = 1;
    chk("t6_vld",   32'(o_valid), 0);
    chk("t6_data",  32'(o_data), 0);
    chk("t6_en",    32'(o_baud_strb_en), 1);
    tick(8 * BIT);
    i_ready = 1;
    send(8'h3C, 0, 0, 0, 1); tick(4);
    chk("t6_next",  32'(got_q[$]), 32'({8'h3C, 2'b00}));

    // Randomised frames, random backpressure
    rnd_rdy = 1;
    for (int n = 0; n < 50; n++) begin
      logic [7:0] d;
      bit pen, podd, bad, stp;
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 7) != 0);
      send(d, pen, podd, bad, stp);
      if (!stp) begin
        tick($urandom_range(0, 40));
        i_rx = 1;
        tick(3);
      end
      tick($urandom_range(0, 20));
    end
    rnd_rdy = 0; i_ready = 1;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine that deserialises an asynchronous 8-bit serial stream: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit. It sits beside `uart_baudgen` and drives that block's `i_rx_strb_en` to re-phase the RX counter on each start edge. It consumes the resulting mid-bit `o_rx_strb` sample strobe and presents received bytes, with error status, on a valid/ready interface to the AXI4-Lite register block.

## Interface
- `SYNC_STAGES`, default 2: metastability synchroniser depth on `i_rx`; legal range ≥ 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_rx`  in  1  asynchronous serial line; idle is high.
- `i_baud_strb`  in  1  mid-bit sample strobe from the baud generator's `o_rx_strb`.
- `o_baud_strb_en`  out  1  holds the baud generator's RX counter at 0 while high; connect to `i_rx_strb_en`.
- `i_parity_en`  in  1  expect a parity bit between data and stop.
- `i_parity_odd`  in  1  selects parity type: 1 = odd, 0 = even.
- `o_data`  out  8  received byte.
- `o_valid`  out  1  `o_data`/`o_frame_err`/`o_parity_err` hold a valid byte.
- `i_ready`  in  1  consumer accepts the byte when `o_valid && i_ready`.
- `o_frame_err`  out  1  stop bit was sampled low; qualified by `o_valid`.
- `o_parity_err`  out  1  parity mismatch; always 0 when parity is disabled; qualified by `o_valid`.
- `o_overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchroniser.** `i_rx` passes through `SYNC_STAGES` flops, all reset to 1, giving `rx_s`. One further flop holds `rx_q` for edge detection.
- **Start edge.** A start edge is defined as `rx_q==1 && rx_s==0`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Strobe-enable output.** `o_baud_strb_en = (state==IDLE)`, decoded combinationally from the state register.
- **IDLE.**
  - On a start edge: go to START.
  - On that same edge, latch `i_parity_en` and `i_parity_odd` into frame-local copies. Changes to these inputs mid-frame have no effect.
- **START.** On `i_baud_strb`:
  - If `rx_s==0`: go to DATA and clear `bit_cnt` (3 bits).
  - Otherwise the edge was a glitch: go to IDLE.
- **DATA.** On `i_baud_strb`:
  - Shift in LSB first: `shreg <= {rx_s, shreg[7:1]}`.
  - When `bit_cnt==7`, go to PARITY if the latched parity enable is set, otherwise go to STOP.
  - Otherwise increment `bit_cnt`.
- **PARITY.** On `i_baud_strb`:
  - Compute `par_err = rx_s ^ (^shreg) ^ par_odd`.
  - Go to STOP.
- **STOP.** On `i_baud_strb`:
  - Compute `frm_err = ~rx_s`.
  - Attempt delivery (see below), then go to IDLE.
- **Delivery.**
  - If `!o_valid || i_ready`: load `o_data`, the error flags, and `o_valid<=1`.
  - Otherwise: pulse `o_overrun` and drop the new byte. The held byte and its flags stay unchanged.
- **Accept.** `o_valid && i_ready` with no simultaneous load clears `o_valid`.
- **Break / stuck-low line.** After a low stop bit the FSM stays in IDLE until the line returns high and falls again. There is no back-to-back restart on a stuck-low line.

## Timing
- **Reset values.**
  - state = IDLE, so `o_baud_strb_en=1`.
  - `o_data=0`, `o_valid=0`, `o_frame_err=0`, `o_parity_err=0`, `o_overrun=0`.
  - `shreg=0`, `bit_cnt=0`, synchroniser flops = 1.
- **Line to edge detect.** From an `i_rx` transition to the start edge being seen takes `SYNC_STAGES` cycles.
- **Start-edge to first strobe.**
  - The state leaves IDLE on the cycle after the edge is detected, releasing the baud counter from 0.
  - The first strobe arrives target/2 cycles later (mid start bit). Later strobes follow every target+1 cycles.
- **Output latency.** `o_valid`, `o_data` and the flags are registered and update on the clock edge after the STOP-state strobe. `o_overrun` is high for exactly that one cycle.
- **Simultaneous load and accept.** If a load and an accept fall in the same cycle, the load wins: `o_valid` stays 1 with the new data, and there is no overrun.
- **Reset mid-frame.** The partial frame is discarded and the FSM returns to IDLE. Because the synchroniser resets high, a line that is already low does not produce a false start.
- **Strobes outside a frame.** `i_baud_strb` is ignored in IDLE.

## Structure
- **Package `uart_pkg`.**
  - `typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} uart_rx_state_e`.
  - `localparam int unsigned UART_DATA_BITS = 8`.
- **Sub-module `uart_sync`.** Parameterised N-flop synchroniser with reset value 1. It is reused later for the TX CTS input.
- **Top-level wiring.** `uart_rx` and `uart_baudgen` are instantiated side by side in the UART top. `o_baud_strb_en` connects to `i_rx_strb_en`.

## Test plan
Conditions for all scenarios: CLK_FREQ=100 MHz, baud code 3'b100 (divider 868, 869 cycles per bit), `SYNC_STAGES=2`.

1. **Clean 8N1 byte.** Send 0x55, 8N1, `i_ready=1` → `o_valid` high for 1 cycle, `o_data=0x55`, `o_frame_err=0`, `o_parity_err=0`, `o_baud_strb_en` low for the whole frame.
2. **Even parity.**
   - Send 0xA3 with parity bit 0 → `o_parity_err=0`.
   - Resend with parity bit 1 → `o_parity_err=1`, `o_data=0xA3`.
3. **Framing error.**
   - Send 0x0F with the stop bit driven 0 and the line held low for 3 bit times → `o_frame_err=1`, a single `o_valid`, no second byte.
   - Line returns high, then send 0x21 → `o_data=0x21`, `o_frame_err=0`.
4. **Start glitch.** Drive `i_rx` low for 100 cycles, then high → FSM returns to IDLE at the first strobe, no `o_valid`, `o_baud_strb_en` back to 1.
5. **Overrun.**
   - With `i_ready=0`, send 0x11 then 0x22 → `o_data` stays 0x11, `o_overrun` pulses 1 cycle at the 0x22 stop strobe.
   - Raise `i_ready` → `o_valid` drops the next cycle.
6. **Reset mid-frame.** Assert `rst_n=0` for 2 cycles after the 4th data bit → all outputs return to reset values. A following 0x3C is received intact.
